// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller:
// wait-state FSM encoding and default stage geometry.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DIV_BUSY  = 2'd1,
    DMEM_WAIT = 2'd2
  } state_e;

  localparam int NSTAGE_DEF  = 5;
  localparam int DEC_STG_DEF = 1;
  localparam int EXE_STG_DEF = 2;
  localparam int MEM_STG_DEF = 3;
  localparam int REG_W_DEF   = 5;
  localparam int TIMEOUT_DEF = 64;
  localparam int CNT_W_DEF   = 32;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use and branch-operand hazard compare.
// Register 0 is hardwired and never a producer.
module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] rs_d_i,
  input  logic [REG_W-1:0] rt_d_i,
  input  logic             branch_d_i,
  input  logic [REG_W-1:0] writereg_e_i,
  input  logic             regwrite_e_i,
  input  logic             memtoreg_e_i,
  input  logic [REG_W-1:0] writereg_m_i,
  input  logic             memtoreg_m_i,
  output logic             lwstall_o,
  output logic             brstall_o
);

  logic e_hit;
  logic m_hit;

  assign e_hit = (writereg_e_i != '0) &&
                 ((writereg_e_i == rs_d_i) ||
                  (writereg_e_i == rt_d_i));

  assign m_hit = (writereg_m_i != '0) &&
                 ((writereg_m_i == rs_d_i) ||
                  (writereg_m_i == rt_d_i));

  assign lwstall_o = memtoreg_e_i & regwrite_e_i & e_hit;

  assign brstall_o = branch_d_i &
                     ((regwrite_e_i & e_hit) |
                      (memtoreg_m_i & m_hit));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Per-stage stall/flush generation with divide/dmem wait FSM,
// wait-state watchdog and stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int NSTAGE  = NSTAGE_DEF,
  parameter int DEC_STG = DEC_STG_DEF,
  parameter int EXE_STG = EXE_STG_DEF,
  parameter int MEM_STG = MEM_STG_DEF,
  parameter int REG_W   = REG_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  rs_d,
  input  logic [REG_W-1:0]  rt_d,
  input  logic              branch_d,
  input  logic [REG_W-1:0]  writereg_e,
  input  logic              regwrite_e,
  input  logic              memtoreg_e,
  input  logic [REG_W-1:0]  writereg_m,
  input  logic              memtoreg_m,
  input  logic              div_start_e,
  input  logic              div_done,
  input  logic              dmem_req_m,
  input  logic              dmem_ready,
  input  logic              imem_ready,
  input  logic              exc_m,
  output logic [NSTAGE-1:0] stall_o,
  output logic [NSTAGE-1:0] flush_o,
  output logic              div_abort_o,
  output logic              redirect_o,
  output logic              err_timeout_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] W_MAX = WAIT_W'(TIMEOUT - 1);

  localparam logic [NSTAGE-1:0] ONE   = NSTAGE'(1);
  localparam logic [NSTAGE-1:0] MSK_D = (ONE << (DEC_STG + 1)) - ONE;
  localparam logic [NSTAGE-1:0] MSK_E = (ONE << (EXE_STG + 1)) - ONE;
  localparam logic [NSTAGE-1:0] MSK_M = (ONE << (MEM_STG + 1)) - ONE;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q;

  logic [NSTAGE-1:0]   stall_c, flush_c;
  logic                abort_c, redir_c;
  logic                lwstall, brstall;
  logic                div_act, waiting;

  hazard_detect #(
    .REG_W (REG_W)
  ) u_hd (
    .rs_d_i       (rs_d),
    .rt_d_i       (rt_d),
    .branch_d_i   (branch_d),
    .writereg_e_i (writereg_e),
    .regwrite_e_i (regwrite_e),
    .memtoreg_e_i (memtoreg_e),
    .writereg_m_i (writereg_m),
    .memtoreg_m_i (memtoreg_m),
    .lwstall_o    (lwstall),
    .brstall_o    (brstall)
  );

  assign div_act = (state_q == DIV_BUSY) ||
                   ((state_q == RUN) && div_start_e);

  // Priority chain: lower sources are masked, not queued.
  always_comb begin
    state_d = state_q;
    stall_c = '0;
    flush_c = '0;
    abort_c = 1'b0;
    redir_c = 1'b0;
    if (!rst) begin
      state_d = RUN;
    end else if (exc_m) begin
      flush_c = MSK_M;
      redir_c = 1'b1;
      abort_c = (state_q == DIV_BUSY) | div_start_e;
      state_d = RUN;
    end else if (dmem_req_m && !dmem_ready) begin
      stall_c = MSK_M;
      flush_c = ONE << (MEM_STG + 1);
      state_d = DMEM_WAIT;
    end else if (div_act && !div_done) begin
      stall_c = MSK_E;
      flush_c = ONE << MEM_STG;
      state_d = DIV_BUSY;
    end else begin
      state_d = RUN;
      if (lwstall || brstall) begin
        stall_c = MSK_D;
        flush_c = ONE << EXE_STG;
      end else if (!imem_ready) begin
        stall_c = ONE;
        flush_c = ONE << DEC_STG;
      end
    end
  end

  assign waiting = (state_q != RUN) && (state_d != RUN);

  always_comb begin
    wait_d = '0;
    err_d  = err_q;
    if (waiting) begin
      wait_d = (wait_q == W_MAX) ? wait_q : wait_q + 1'b1;
      if (wait_q == W_MAX) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      cnt_q   <= cnt_q + CNT_W'(|stall_c);
    end
  end

  assign stall_o       = stall_c;
  assign flush_o       = flush_c;
  assign div_abort_o   = abort_c;
  assign redirect_o    = redir_c;
  assign err_timeout_o = err_q;
  assign stall_cnt_o   = cnt_q;

endmodule
